// File: rtl/sorted_merge_pkg.sv
// Shared configuration and state encoding for the sorted_merge block.
package sorted_merge_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_DATA   = 8;
  localparam int CNT_W      = $clog2(NUM_DATA) + 1;
  localparam int OCNT_W     = $clog2(2 * NUM_DATA) + 1;

  typedef enum logic [2:0] {
    MERGE   = 3'd0,
    DRAIN_A = 3'd1,
    DRAIN_B = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } merge_state_t;

endpackage

// File: rtl/sorted_merge_out_reg.sv
// Output register stage (merge_out_reg): holds m_valid/m_data/m_last and
// reports when the slot can accept a new word.
module sorted_merge_out_reg
  import sorted_merge_pkg::*;
#(
  parameter int DATA_WIDTH = sorted_merge_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  m_ready,
  output logic                  slot_free,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;

  assign slot_free = !m_valid_q || m_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (slot_free) begin
      m_valid_d = load;
      m_last_d  = load && load_last;
      if (load) m_data_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: rtl/sorted_merge.sv
// Streaming merge of two ascending frames into one ascending frame.
// Optional input-order checker enabled by MERGE_ORDER_CHECK_EN.
//
// state   | meaning
// MERGE   | both inputs live; take the smaller head (ties to A)
// DRAIN_A | B exhausted; pass remaining A words
// DRAIN_B | A exhausted; pass remaining B words
// FLUSH   | both exhausted; wait for the m_last handshake
// DONE    | one-cycle done pulse; counters cleared
module sorted_merge
  import sorted_merge_pkg::*;
#(
  parameter int DATA_WIDTH = sorted_merge_pkg::DATA_WIDTH,
  parameter int NUM_DATA   = sorted_merge_pkg::NUM_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  done,
  output logic                  order_err
);

  localparam int LCNT_W  = $clog2(NUM_DATA) + 1;
  localparam int LOCNT_W = $clog2(2 * NUM_DATA) + 1;
  localparam logic [LCNT_W-1:0]  LAST_IN  = LCNT_W'(NUM_DATA - 1);
  localparam logic [LOCNT_W-1:0] LAST_OUT = LOCNT_W'(2 * NUM_DATA - 1);

  merge_state_t         state_q, state_d;
  logic [LCNT_W-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [LOCNT_W-1:0]   o_cnt_q, o_cnt_d;
  logic                 slot_free, a_hs, b_hs, load;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      MERGE: if (a_valid && b_valid && slot_free) begin
        if (a_data <= b_data) a_ready = 1'b1;
        else                  b_ready = 1'b1;
      end
      DRAIN_A: a_ready = slot_free;
      DRAIN_B: b_ready = slot_free;
      default: ;
    endcase
  end

  assign a_hs = a_valid && a_ready;
  assign b_hs = b_valid && b_ready;
  assign load = a_hs || b_hs;

  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    o_cnt_d = o_cnt_q;
    if (a_hs) begin
      a_cnt_d = a_cnt_q + LCNT_W'(1);
      if (a_cnt_q == LAST_IN) state_d = (state_q == MERGE) ? DRAIN_B : FLUSH;
    end
    if (b_hs) begin
      b_cnt_d = b_cnt_q + LCNT_W'(1);
      if (b_cnt_q == LAST_IN) state_d = (state_q == MERGE) ? DRAIN_A : FLUSH;
    end
    if (load) o_cnt_d = o_cnt_q + LOCNT_W'(1);
    case (state_q)
      FLUSH: if (m_valid && m_ready && m_last) state_d = DONE;
      DONE: begin
        a_cnt_d = '0;
        b_cnt_d = '0;
        o_cnt_d = '0;
        state_d = MERGE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MERGE;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      o_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      o_cnt_q <= o_cnt_d;
    end
  end

  assign done = (state_q == DONE);

  sorted_merge_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (a_hs ? a_data : b_data),
    .load_last (o_cnt_q == LAST_OUT),
    .m_ready   (m_ready),
    .slot_free (slot_free),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last)
  );

`ifdef MERGE_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic                  order_err_q, order_err_d;

  always_comb begin
    prev_a_d    = a_hs ? a_data : prev_a_q;
    prev_b_d    = b_hs ? b_data : prev_b_q;
    order_err_d = order_err_q
                | (a_hs && (a_cnt_q != '0) && (a_data < prev_a_q))
                | (b_hs && (b_cnt_q != '0) && (b_data < prev_b_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_q    <= '0;
      prev_b_q    <= '0;
      order_err_q <= 1'b0;
    end else begin
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule
